oam_dma_bus: RTL and testbench

Bus stage directly downstream of the sm83 core's memory interface. It sits between the core's r_addr/w_addr/w_data/w_wen/r_data port and the system memory port. It owns the DMA source register at 0xFF46 and the 127-byte HRAM. It runs the OAM DMA engine, which copies 160 bytes from {src,8'h00} to 0xFE00. While the copy runs, the core is fenced off the main bus.

---
 rtl/oam_dma_bus_pkg.sv | 33 +++
 rtl/oam_dma_bus_if.sv | 36 +++
 rtl/oam_dma_bus_hram.sv | 34 +++
 rtl/oam_dma_bus.sv | 153 +++++++++++++++
 tb/tb_oam_dma_bus.sv | 315 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/oam_dma_bus_pkg.sv
// -----------------------------------------------------------------------------
// oam_dma_bus_pkg
// Shared types and constants for the OAM DMA bus stage that sits between the
// sm83 core memory port and the system memory port.
//   addr_t / data_t : 16-bit address and 8-bit data used on every bus port
//   dma_state_t     : DMA engine state (IDLE / START / XFER)
//   HRAM_BASE/TOP   : inclusive address window of the 127-byte HRAM
// -----------------------------------------------------------------------------
package oam_dma_bus_pkg;

  typedef logic [15:0] addr_t;
  typedef logic [7:0]  data_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    XFER  = 2'd2
  } dma_state_t;

  localparam addr_t HRAM_BASE = 16'hFF80;
  localparam addr_t HRAM_TOP  = 16'hFFFE;

  // True when the address falls inside the HRAM window (0xFF80..0xFFFE).
  function automatic logic is_hram(input addr_t a);
    return (a >= HRAM_BASE) && (a <= HRAM_TOP);
  endfunction

  // Sources in the echo region (0xE0xx and up) are folded back onto WRAM.
  function automatic data_t eff_src(input data_t s);
    return (s >= 8'hE0) ? data_t'(s - 8'h20) : s;
  endfunction

endpackage

// File: rtl/oam_dma_bus_if.sv
// -----------------------------------------------------------------------------
// oam_dma_bus_if
// Byte-wide memory port with separate read and write addresses.
//   r_addr : read address (combinational read)
//   r_data : read data returned for r_addr
//   w_addr : write address
//   w_data : write data
//   w_wen  : write enable, sampled at the rising clock edge
// The master drives addresses and write data; the slave returns read data.
// -----------------------------------------------------------------------------
interface oam_dma_bus_if;
  import oam_dma_bus_pkg::*;

  addr_t r_addr;
  data_t r_data;
  addr_t w_addr;
  data_t w_data;
  logic  w_wen;

  modport master (
    output r_addr,
    output w_addr,
    output w_data,
    output w_wen,
    input  r_data
  );

  modport slave (
    input  r_addr,
    input  w_addr,
    input  w_data,
    input  w_wen,
    output r_data
  );

endinterface

// File: rtl/oam_dma_bus_hram.sv
// -----------------------------------------------------------------------------
// oam_dma_bus_hram
// 127 x 8 high RAM: synchronous write, asynchronous read. Contents are not
// reset. A read of the address being written in the same cycle returns the
// old contents.
//   clk   : clock
//   we    : write enable
//   waddr : write index (0..126)
//   wdata : write data
//   raddr : read index (0..126)
//   rdata : read data, combinational from raddr
// -----------------------------------------------------------------------------
module oam_dma_bus_hram
  import oam_dma_bus_pkg::*;
(
  input  logic       clk,
  input  logic       we,
  input  logic [6:0] waddr,
  input  data_t      wdata,
  input  logic [6:0] raddr,
  output data_t      rdata
);

  data_t mem [0:126];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/oam_dma_bus.sv
// -----------------------------------------------------------------------------
// oam_dma_bus
// Bus stage directly downstream of the sm83 core. Owns the DMA source
// register, the HRAM and the OAM DMA engine that copies DMA_LEN bytes from
// {src,8'h00} to OAM_BASE, one byte per clock. While bytes are being copied
// the core is fenced off the main bus (reads return 8'hFF, writes dropped).
//   clk        : clock
//   rst_n      : asynchronous active-low reset
//   cpu        : core-side port (slave modport)
//   mem        : system memory port (master modport)
//   dma_active : high during transfer cycles only
// -----------------------------------------------------------------------------
module oam_dma_bus
  import oam_dma_bus_pkg::*;
#(
  parameter int    START_DELAY  = 1,
  parameter int    DMA_LEN      = 160,
  parameter addr_t OAM_BASE     = 16'hFE00,
  parameter addr_t DMA_REG_ADDR = 16'hFF46
) (
  input  logic                clk,
  input  logic                rst_n,
  oam_dma_bus_if.slave        cpu,
  oam_dma_bus_if.master       mem,
  output logic                dma_active
);

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);
  localparam logic [3:0] DLY_INIT = 4'(START_DELAY);

  dma_state_t state, state_n;
  data_t      src_reg, src_n;
  logic [7:0] idx, idx_n;
  logic [3:0] dly, dly_n;

  logic  xfer;
  logic  dma_wr;
  logic  hram_wr;
  logic  main_wr;
  data_t hram_rdata;

  // Write decode: each core write goes to exactly one of HRAM, DMAREG, MAIN.
  assign dma_wr  = cpu.w_wen && (cpu.w_addr == DMA_REG_ADDR);
  assign hram_wr = cpu.w_wen && is_hram(cpu.w_addr);
  assign main_wr = cpu.w_wen && !is_hram(cpu.w_addr) && (cpu.w_addr != DMA_REG_ADDR);

  assign xfer = (state == XFER);

  // HRAM stays reachable for the core during DMA.
  oam_dma_bus_hram u_hram (
    .clk   (clk),
    .we    (hram_wr),
    .waddr (cpu.w_addr[6:0]),
    .wdata (cpu.w_data),
    .raddr (cpu.r_addr[6:0]),
    .rdata (hram_rdata)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      src_reg <= 8'hFF;
      idx     <= '0;
      dly     <= '0;
    end else begin
      state   <= state_n;
      src_reg <= src_n;
      idx     <= idx_n;
      dly     <= dly_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    src_n   = src_reg;
    idx_n   = idx;
    dly_n   = dly;
    case (state)
      IDLE: begin
      end
      START: begin
        // dly was loaded with START_DELAY on the register write, so this
        // state lasts exactly START_DELAY clocks.
        if (dly <= 4'd1) begin
          state_n = XFER;
          dly_n   = '0;
          idx_n   = '0;
        end else begin
          dly_n = dly - 4'd1;
        end
      end
      XFER: begin
        if (idx == LAST_IDX) begin
          state_n = IDLE;
          idx_n   = '0;
        end else begin
          idx_n = idx + 8'd1;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
    // A register write restarts from any state and beats the return to IDLE
    // on the last byte; the byte on the bus this cycle still gets written.
    if (dma_wr) begin
      state_n = START;
      src_n   = cpu.w_data;
      idx_n   = '0;
      dly_n   = DLY_INIT;
    end
  end

  // Outputs: memory address mux
  always_comb begin
    mem.r_addr = cpu.r_addr;
    mem.w_addr = cpu.w_addr;
    if (xfer) begin
      mem.r_addr = {eff_src(src_reg), idx};
      mem.w_addr = OAM_BASE + {8'h00, idx};
    end
  end

  // Outputs: write data / enable. Reset gates the forwarded enable so the
  // memory port is quiet for the whole time rst_n is low.
  always_comb begin
    mem.w_data = cpu.w_data;
    mem.w_wen  = main_wr && rst_n;
    if (xfer) begin
      mem.w_data = mem.r_data;
      mem.w_wen  = 1'b1;
    end
  end

  // Outputs: core read mux. During a transfer mem.r_data belongs to the DMA
  // source address, so MAIN reads are masked to 8'hFF.
  always_comb begin
    if (is_hram(cpu.r_addr)) begin
      cpu.r_data = hram_rdata;
    end else if (cpu.r_addr == DMA_REG_ADDR) begin
      cpu.r_data = src_reg;
    end else if (xfer) begin
      cpu.r_data = 8'hFF;
    end else begin
      cpu.r_data = mem.r_data;
    end
  end

  assign dma_active = xfer;

endmodule

// File: tb/tb_oam_dma_bus.sv
module tb_oam_dma_bus;
  import oam_dma_bus_pkg::*;

  localparam int SD  = 1;
  localparam int LEN = 160;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic dma_active;

  oam_dma_bus_if cpu_if ();
  oam_dma_bus_if mem_if ();

  oam_dma_bus #(
    .START_DELAY  (SD),
    .DMA_LEN      (LEN),
    .OAM_BASE     (16'hFE00),
    .DMA_REG_ADDR (16'hFF46)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu        (cpu_if),
    .mem        (mem_if),
    .dma_active (dma_active)
  );

  always #5 clk = ~clk;

  // ---------------- system memory model ----------------
  function automatic data_t pat(input addr_t a);
    data_t t;
    if (a[15:8] == 8'hC1) return a[7:0] ^ 8'h5A;
    t = a[7:0] * 8'd3 + a[15:8] * 8'd5 + 8'd1;
    return t;
  endfunction

  data_t sys_mem [0:65535];
  logic  init_done = 1'b0;

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 65536; i++) sys_mem[i] <= pat(16'(i));
      init_done <= 1'b1;
    end else if (mem_if.w_wen) begin
      sys_mem[mem_if.w_addr] <= mem_if.w_data;
    end
  end

  assign mem_if.r_data = sys_mem[mem_if.r_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard queues ----------------
  typedef struct {
    int    cyc;
    addr_t w_addr;
    data_t w_data;
    addr_t r_addr;
    bit    dma;
  } wr_t;
  typedef struct {
    int    cyc;
    addr_t addr;
    data_t exp;
  } rd_t;
  typedef struct {
    addr_t addr;
    data_t exp;
  } mc_t;

  wr_t wq[$];
  rd_t rq[$];
  mc_t mq[$];
  int  end_cyc = -1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin : mon
    wr_t e;
    rd_t r;
    mc_t m;
    if (init_done) begin
      if (!rst_n) begin
        chk("rst_wen", mem_if.w_wen, 0);
        chk("rst_active", dma_active, 0);
      end else begin
        while (wq.size() > 0 && wq[0].cyc < cyc) begin
          chk("stale_write_cycle", wq[0].cyc, cyc);
          void'(wq.pop_front());
        end
        if (wq.size() > 0 && wq[0].cyc == cyc) begin
          e = wq.pop_front();
          chk("wen", mem_if.w_wen, 1);
          chk("w_addr", mem_if.w_addr, e.w_addr);
          chk("w_data", mem_if.w_data, e.w_data);
          chk("dma_active", dma_active, e.dma);
          if (e.dma) chk("r_addr", mem_if.r_addr, e.r_addr);
        end else begin
          chk("idle_wen", mem_if.w_wen, 0);
          chk("idle_active", dma_active, 0);
        end
      end
      while (rq.size() > 0 && rq[0].cyc < cyc) begin
        chk("stale_read_cycle", rq[0].cyc, cyc);
        void'(rq.pop_front());
      end
      while (rq.size() > 0 && rq[0].cyc == cyc) begin
        r = rq.pop_front();
        chk($sformatf("cpu_r_data@%h", r.addr), cpu_if.r_data, r.exp);
      end
      while (mq.size() > 0) begin
        m = mq.pop_front();
        chk($sformatf("mem@%h", m.addr), sys_mem[m.addr], m.exp);
      end
      if (cyc == end_cyc) chk("pending_writes", wq.size(), 0);
    end
  end

  // ---------------- reference model ----------------
  data_t ref_mem  [0:65535];
  data_t hram_ref [0:126];
  data_t m_src;
  int    m_start = -1;
  int    m_end   = -1;

  function automatic bit m_active(input int k);
    return (k >= m_start) && (k <= m_end);
  endfunction

  function automatic data_t src_page(input data_t s);
    if (s >= 8'hE0) return s - 8'h20;
    return s;
  endfunction

  function automatic data_t exp_read(input addr_t a);
    if (a >= 16'hFF80 && a <= 16'hFFFE) return hram_ref[a - 16'hFF80];
    if (a == 16'hFF46) return m_src;
    if (m_active(cyc)) return 8'hFF;
    return ref_mem[a];
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_write(input addr_t a, input data_t d);
    int    k;
    data_t eff;
    k = cyc;
    cpu_if.w_addr = a;
    cpu_if.w_data = d;
    cpu_if.w_wen  = 1'b1;
    if (a == 16'hFF46) begin
      m_src = d;
      while (wq.size() > 0 && wq[$].cyc > k) void'(wq.pop_back());
      eff     = src_page(d);
      m_start = k + 1 + SD;
      m_end   = m_start + LEN - 1;
      for (int i = 0; i < LEN; i++) begin
        wq.push_back(wr_t'{m_start + i, 16'hFE00 + 16'(i),
                           ref_mem[{eff, 8'(i)}], {eff, 8'(i)}, 1'b1});
      end
    end else if (a >= 16'hFF80 && a <= 16'hFFFE) begin
      hram_ref[a - 16'hFF80] = d;
    end else if (!m_active(k)) begin
      wq.push_front(wr_t'{k, a, d, 16'h0000, 1'b0});
      ref_mem[a] = d;
    end
    tick(1);
    cpu_if.w_wen = 1'b0;
  endtask

  task automatic do_read(input addr_t a);
    cpu_if.r_addr = a;
    rq.push_back(rd_t'{cyc, a, exp_read(a)});
    tick(1);
  endtask

  task automatic wait_done();
    while (cyc <= m_end) tick(1);
    tick(1);
  endtask

  task automatic check_oam(input data_t src);
    data_t eff;
    eff = src_page(src);
    for (int i = 0; i < LEN; i++)
      mq.push_back(mc_t'{16'hFE00 + 16'(i), ref_mem[{eff, 8'(i)}]});
    tick(1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    addr_t a;
    data_t s, d;
    int    pick;
    cpu_if.r_addr = '0;
    cpu_if.w_addr = '0;
    cpu_if.w_data = '0;
    cpu_if.w_wen  = 1'b0;
    rst_n = 1'b0;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(16'(i));
    m_src = 8'hFF;

    // Reset state
    tick(1);
    do_read(16'hFF46);
    do_read(16'hC000);
    rst_n = 1'b1;
    tick(1);
    do_read(16'hC000);

    // Basic transfer from C1 plus fencing during XFER
    do_write(16'hFF46, 8'hC1);
    tick(SD + 5);
    do_read(16'hFF46);
    do_read(16'hC000);
    do_write(16'hD000, 8'h11);
    do_write(16'hFF90, 8'h3C);
    do_read(16'hFF90);
    wait_done();
    for (int i = 0; i < LEN; i++)
      mq.push_back(mc_t'{16'hFE00 + 16'(i), 8'(i) ^ 8'h5A});
    mq.push_back(mc_t'{16'hD000, ref_mem[16'hD000]});
    tick(1);
    do_read(16'hFF46);
    do_read(16'hFF90);

    // Restart at idx 50
    do_write(16'hFF46, 8'hC1);
    tick(SD + 50);
    do_write(16'hFF46, 8'hC2);
    wait_done();
    check_oam(8'hC2);

    // Echo-region source
    do_write(16'hFF46, 8'hE3);
    wait_done();
    check_oam(8'hE3);
    do_read(16'hFF46);

    // Reset in the middle of a transfer (idx 80)
    do_write(16'hFF46, 8'hE3);
    tick(SD + 80);
    rst_n = 1'b0;
    while (wq.size() > 0 && wq[$].cyc >= cyc) void'(wq.pop_back());
    m_start = -1;
    m_end   = -1;
    m_src   = 8'hFF;
    cpu_if.r_addr = 16'hFF46;
    rq.push_back(rd_t'{cyc, 16'hFF46, 8'hFF});
    tick(1);
    rq.push_back(rd_t'{cyc, 16'hFF46, 8'hFF});
    tick(1);
    rst_n = 1'b1;
    tick(1);
    do_read(16'hC000);
    do_read(16'hFF90);

    // Idle forwarding; an FF46 write is never forwarded
    do_write(16'hC000, 8'hAB);
    do_read(16'hC000);
    do_write(16'hFF46, 8'hC5);
    wait_done();
    check_oam(8'hC5);

    // Randomized transfers with core traffic and optional restarts
    for (int it = 0; it < 8; it++) begin
      pick = int'($urandom_range(0, 31));
      s = (pick < 16) ? 8'(8'hC0 + pick) : 8'(8'hE0 + pick - 16);
      do_write(16'hFF46, s);
      tick(SD);
      for (int j = 0; j < 20; j++) begin
        case ($urandom_range(0, 3))
          0: begin
            a = 16'hFF80 + 16'($urandom_range(0, 126));
            d = 8'($urandom);
            do_write(a, d);
            do_read(a);
          end
          1: do_read(16'hC000 + 16'($urandom_range(0, 16'h1FFF)));
          2: do_write(16'hD000 + 16'($urandom_range(0, 16'h0FFF)), 8'($urandom));
          default: tick(1);
        endcase
      end
      if ($urandom_range(0, 1) == 1) begin
        pick = int'($urandom_range(0, 31));
        s = (pick < 16) ? 8'(8'hC0 + pick) : 8'(8'hE0 + pick - 16);
        do_write(16'hFF46, s);
      end
      wait_done();
      check_oam(s);
      a = 16'hD000 + 16'($urandom_range(0, 16'h0FFF));
      do_write(a, 8'($urandom));
      do_read(a);
    end

    tick(3);
    end_cyc = cyc;
    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
